wb_commit: RTL and testbench

//  Writeback commit stage: the writer side of the GPR file. Merges in-order pipeline

---
 rtl/wb_commit_pkg.sv | 22 ++
 rtl/wb_hold_fifo.sv | 125 ++++++++++++
 rtl/wb_commit.sv | 114 +++++++++++
 tb/tb_wb_commit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared widths, entry type and source-select encoding for the writeback commit stage.
package wb_commit_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 32;
  localparam int WB_FIFO_DEPTH = 2;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_LU   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_hold_fifo.sv
// Holding FIFO for displaced long-latency results: per-entry valid bits,
// kill-by-address, head skips killed slots, two pending-address match ports.
module wb_hold_fifo
  import wb_commit_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  wb_entry_t             i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_kill,
  input  logic [REG_ADDR_W-1:0] i_kill_addr,
  input  logic [REG_ADDR_W-1:0] i_match_addr1,
  input  logic [REG_ADDR_W-1:0] i_match_addr2,
  output logic                  o_match1,
  output logic                  o_match2,
  output logic                  o_head_valid,
  output wb_entry_t             o_head_entry,
  output logic [CW-1:0]         o_count
);

  logic [DEPTH-1:0] r_valid;
  wb_entry_t        r_entry [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_kill_mask;
  logic [DEPTH-1:0] w_v_kill;
  logic [DEPTH-1:0] w_v_pop;
  logic [DEPTH-1:0] w_v_next;
  logic [PW-1:0]    w_head_idx;
  logic             w_head_found;
  logic [PW-1:0]    w_scan_idx;
  logic [PW-1:0]    w_head_trim;
  logic [PW-1:0]    w_tail_trim;
  logic [PW-1:0]    w_tail_next;
  logic [CW-1:0]    w_count_next;

  always_comb begin
    w_kill_mask = '0;
    o_match1    = 1'b0;
    o_match2    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_mask[i] = i_kill & r_valid[i] & (r_entry[i].waddr == i_kill_addr);
      o_match1       = o_match1 | (r_valid[i] & (r_entry[i].waddr == i_match_addr1));
      o_match2       = o_match2 | (r_valid[i] & (r_entry[i].waddr == i_match_addr2));
    end
  end

  assign w_v_kill = r_valid & ~w_kill_mask;

  // Oldest surviving entry, scanning forward from the head pointer.
  always_comb begin
    w_head_idx   = r_head;
    w_head_found = 1'b0;
    w_scan_idx   = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = r_head + PW'(i);
      if (!w_head_found && w_v_kill[w_scan_idx]) begin
        w_head_idx   = w_scan_idx;
        w_head_found = 1'b1;
      end
    end
  end

  assign o_head_valid = w_head_found;
  assign o_head_entry = r_entry[w_head_idx];

  // Re-compact the occupied window after kill/pop so the tail slot is always free
  // whenever count < DEPTH.
  always_comb begin
    w_v_pop = w_v_kill;
    if (i_pop && w_head_found) begin
      w_v_pop[w_head_idx] = 1'b0;
    end
    w_head_trim = r_head;
    w_tail_trim = r_tail;
    if (w_v_pop == '0) begin
      w_head_trim = r_tail;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!w_v_pop[w_head_trim]) w_head_trim = w_head_trim + PW'(1);
        if (!w_v_pop[w_tail_trim - PW'(1)]) w_tail_trim = w_tail_trim - PW'(1);
      end
    end
    w_v_next    = w_v_pop;
    w_tail_next = w_tail_trim;
    if (i_push) begin
      w_v_next[w_tail_trim] = 1'b1;
      w_tail_next           = w_tail_trim + PW'(1);
    end
    w_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + CW'(w_v_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_v_next;
      r_head  <= w_head_trim;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_entry[w_tail_trim] <= i_push_entry;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: picks pipeline, held long-latency or direct LU result
// for the registered regfile write port, and flags decode reads of pending entries.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wen,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [REG_DATA_W-1:0] mem_wdata,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_waddr,
  input  logic [REG_DATA_W-1:0] lu_wdata,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REG_DATA_W-1:0] wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  input  logic                  ren1,
  input  logic                  ren2,
  output logic                  stallreq
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [REG_DATA_W-1:0] r_wdata;

  logic          w_pipe;
  logic          w_lu_acc;
  logic          w_lu_live;
  wb_src_e       w_src;
  logic          w_pop;
  logic          w_push;
  logic          w_hit1;
  logic          w_hit2;
  logic          w_head_valid;
  wb_entry_t     w_head_entry;
  wb_entry_t     w_lu_entry;
  logic [CW-1:0] w_count;

  assign w_pipe    = mem_wen & (mem_waddr != ZERO_REG);
  assign w_lu_acc  = lu_valid & lu_ready;
  // Writes to r0 and results overtaken by a same-cycle pipeline write are dropped.
  assign w_lu_live = w_lu_acc & (lu_waddr != ZERO_REG) &
                     ~(w_pipe & (lu_waddr == mem_waddr));

  always_comb begin
    w_src = SRC_NONE;
    if (w_pipe)             w_src = SRC_PIPE;
    else if (w_head_valid)  w_src = SRC_FIFO;
    else if (w_lu_live)     w_src = SRC_LU;
  end

  assign w_pop      = (w_src == SRC_FIFO);
  assign w_push     = w_lu_live & (w_src != SRC_LU);
  assign w_lu_entry = '{waddr: lu_waddr, wdata: lu_wdata};

  wb_hold_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_entry  (w_lu_entry),
    .i_pop         (w_pop),
    .i_kill        (w_pipe),
    .i_kill_addr   (mem_waddr),
    .i_match_addr1 (raddr1),
    .i_match_addr2 (raddr2),
    .o_match1      (w_hit1),
    .o_match2      (w_hit2),
    .o_head_valid  (w_head_valid),
    .o_head_entry  (w_head_entry),
    .o_count       (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (w_src)
        SRC_PIPE: begin
          r_we    <= 1'b1;
          r_waddr <= mem_waddr;
          r_wdata <= mem_wdata;
        end
        SRC_FIFO: begin
          r_we    <= 1'b1;
          r_waddr <= w_head_entry.waddr;
          r_wdata <= w_head_entry.wdata;
        end
        SRC_LU: begin
          r_we    <= 1'b1;
          r_waddr <= lu_waddr;
          r_wdata <= lu_wdata;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign lu_ready = (w_count != CW'(DEPTH));
  assign stallreq = (ren1 & (raddr1 != ZERO_REG) & w_hit1) |
                    (ren2 & (raddr2 != ZERO_REG) & w_hit2);

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit with hand-computed expectations.
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        ren1;
  logic        ren2;
  logic        stallreq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .ren1      (ren1),
    .ren2      (ren2),
    .stallreq  (stallreq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    mem_wen = en; mem_waddr = a; mem_wdata = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v; lu_waddr = a; lu_wdata = d;
  endtask

  task automatic chk_wr(input string tag, input logic e_we, input logic [4:0] e_a,
                        input logic [31:0] e_d);
    chk({tag, ".we"}, 32'(we), 32'(e_we));
    chk({tag, ".waddr"}, 32'(waddr), 32'(e_a));
    chk({tag, ".wdata"}, wdata, e_d);
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    raddr1 = 5'd5; raddr2 = 5'd0; ren1 = 1'b1; ren2 = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle.we", 32'(we), 32'd0);
      chk("idle.lu_ready", 32'(lu_ready), 32'd1);
      chk("idle.stallreq", 32'(stallreq), 32'd0);
    end
    chk("idle.waddr", 32'(waddr), 32'd0);
    chk("idle.wdata", wdata, 32'd0);

    // 2: LU alone takes the direct path
    lu(1'b1, 5'd5, 32'hAAAA);
    #1 chk("t2.lu_ready", 32'(lu_ready), 32'd1);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    chk_wr("t2.direct", 1'b1, 5'd5, 32'hAAAA);
    chk("t2.count", 32'(dut.u_fifo.o_count), 32'd0);
    chk("t2.stall", 32'(stallreq), 32'd0);
    cyc();
    chk_wr("t2.hold", 1'b0, 5'd5, 32'hAAAA);

    // 3: two LU results displaced by a busy pipeline
    pipe(1'b1, 5'd8, 32'h88);
    lu(1'b1, 5'd6, 32'h66);
    cyc();
    chk_wr("t3.pipe0", 1'b1, 5'd8, 32'h88);
    lu(1'b1, 5'd7, 32'h77);
    #1 chk("t3.ready1", 32'(lu_ready), 32'd1);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    raddr1 = 5'd6;
    #1;
    chk("t3.ready_full", 32'(lu_ready), 32'd0);
    chk("t3.stall_r6", 32'(stallreq), 32'd1);
    chk("t3.count", 32'(dut.u_fifo.o_count), 32'd2);
    ren1 = 1'b0; ren2 = 1'b1; raddr2 = 5'd7;
    #1 chk("t3.stall_r7_port2", 32'(stallreq), 32'd1);
    ren2 = 1'b0;
    #1 chk("t3.stall_noren", 32'(stallreq), 32'd0);
    ren1 = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    #1 chk("t3.ready_full_pop", 32'(lu_ready), 32'd0);
    cyc();
    chk_wr("t3.drain_r6", 1'b1, 5'd6, 32'h66);
    chk("t3.ready_after_pop", 32'(lu_ready), 32'd1);
    chk("t3.stall_r6_gone", 32'(stallreq), 32'd0);
    cyc();
    chk_wr("t3.drain_r7", 1'b1, 5'd7, 32'h77);
    cyc();
    chk("t3.idle_we", 32'(we), 32'd0);

    // 4: pipeline write kills a pending entry for the same register
    pipe(1'b1, 5'd10, 32'h1010);
    lu(1'b1, 5'd9, 32'h11);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd9, 32'h22);
    raddr1 = 5'd9;
    #1;
    chk("t4.stall_before", 32'(stallreq), 32'd1);
    chk("t4.count_before", 32'(dut.u_fifo.o_count), 32'd1);
    cyc();
    pipe(1'b0, 5'd0, 32'h0);
    chk_wr("t4.kill_write", 1'b1, 5'd9, 32'h22);
    chk("t4.count_after", 32'(dut.u_fifo.o_count), 32'd0);
    chk("t4.stall_after", 32'(stallreq), 32'd0);
    cyc();
    chk_wr("t4.no_stale", 1'b0, 5'd9, 32'h22);

    // 5: r0 pipeline write suppressed, r0 LU accepted and dropped
    pipe(1'b1, 5'd10, 32'h1010);
    lu(1'b1, 5'd3, 32'h33);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd0, 32'hDEAD);
    cyc();
    chk_wr("t5.r3_over_r0", 1'b1, 5'd3, 32'h33);
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b1, 5'd0, 32'hBEEF);
    #1 chk("t5.ready_r0", 32'(lu_ready), 32'd1);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    chk("t5.r0_no_we", 32'(we), 32'd0);
    chk("t5.r0_count", 32'(dut.u_fifo.o_count), 32'd0);

    // same-cycle LU and pipeline to the same register: LU dropped
    pipe(1'b1, 5'd11, 32'h2222);
    lu(1'b1, 5'd11, 32'h1111);
    cyc();
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    chk_wr("t5.waw_same", 1'b1, 5'd11, 32'h2222);
    chk("t5.waw_count", 32'(dut.u_fifo.o_count), 32'd0);
    cyc();
    chk("t5.waw_idle", 32'(we), 32'd0);

    // kill of the youngest entry, then refill keeps age order
    pipe(1'b1, 5'd12, 32'hC);
    lu(1'b1, 5'd13, 32'h13);
    cyc();
    lu(1'b1, 5'd14, 32'h14);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd14, 32'h4444);
    cyc();
    chk_wr("tk.kill_tail", 1'b1, 5'd14, 32'h4444);
    chk("tk.count1", 32'(dut.u_fifo.o_count), 32'd1);
    pipe(1'b1, 5'd12, 32'hC);
    lu(1'b1, 5'd16, 32'h16);
    #1 chk("tk.ready", 32'(lu_ready), 32'd1);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    chk("tk.count2", 32'(dut.u_fifo.o_count), 32'd2);
    cyc();
    chk_wr("tk.drain_r13", 1'b1, 5'd13, 32'h13);
    cyc();
    chk_wr("tk.drain_r16", 1'b1, 5'd16, 32'h16);
    cyc();
    chk("tk.idle", 32'(we), 32'd0);

    // 6: reset with FIFO full
    pipe(1'b1, 5'd12, 32'hC);
    lu(1'b1, 5'd13, 32'h13);
    cyc();
    lu(1'b1, 5'd14, 32'h14);
    cyc();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    raddr1 = 5'd13;
    #1;
    chk("t6.ready_full", 32'(lu_ready), 32'd0);
    chk("t6.stall_full", 32'(stallreq), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6.count", 32'(dut.u_fifo.o_count), 32'd0);
    chk("t6.ready", 32'(lu_ready), 32'd1);
    chk("t6.stall", 32'(stallreq), 32'd0);
    chk_wr("t6.outputs", 1'b0, 5'd0, 32'h0);
    cyc();
    chk("t6.post_we", 32'(we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
